// File: rtl/s1_serial_tx_pkg.sv
// Shared sen/sd link definitions: field widths, burst size and TX state encoding.
// The RB2 receiver uses the same field widths.
package s1_serial_tx_pkg;

    localparam int unsigned ADDR_W  = 3;
    localparam int unsigned DATA_W  = 18;
    localparam int unsigned NUM_PKT = 8;
    localparam int unsigned PKT_W   = ADDR_W + DATA_W;
    localparam int unsigned CNT_W   = 5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_DONE
    } tx_state_e;

endpackage

// File: rtl/s1_serial_tx.sv
// Transmit end of the sen/sd link: reads RB1 words 0..NUM_PKT-1 and sends each
// as an MSB-first {address, data} packet, one bit per clk with sen high.
module s1_serial_tx
    import s1_serial_tx_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              RB1_RW,
    output logic [ADDR_W-1:0] RB1_A,
    input  logic [DATA_W-1:0] RB1_Q,
    output logic              sen,
    output logic              sd,
    output logic              S1_done
);

    tx_state_e          state_q, state_d;
    logic [ADDR_W-1:0]  rb1_a_q, rb1_a_d;
    logic [PKT_W-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [ADDR_W-1:0]  pkt_cnt_q, pkt_cnt_d;
    logic               sen_q, sen_d;
    logic               sd_q, sd_d;
    logic               done_q, done_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            rb1_a_q   <= '0;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            pkt_cnt_q <= '0;
            sen_q     <= 1'b0;
            sd_q      <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rb1_a_q   <= rb1_a_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            pkt_cnt_q <= pkt_cnt_d;
            sen_q     <= sen_d;
            sd_q      <= sd_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        rb1_a_d   = rb1_a_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        pkt_cnt_d = pkt_cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_LOAD;
                    rb1_a_d   = '0;
                    pkt_cnt_d = '0;
                end
            end
            ST_LOAD: begin
                shreg_d   = {pkt_cnt_q, RB1_Q};
                bit_cnt_d = CNT_W'(PKT_W - 1);
                state_d   = ST_SHIFT;
            end
            ST_SHIFT: begin
                shreg_d   = shreg_q << 1;
                bit_cnt_d = bit_cnt_q - CNT_W'(1);
                if (bit_cnt_q == '0) begin
                    bit_cnt_d = '0;
                    if (pkt_cnt_q == ADDR_W'(NUM_PKT - 1)) begin
                        state_d = ST_DONE;
                    end else begin
                        pkt_cnt_d = pkt_cnt_q + ADDR_W'(1);
                        rb1_a_d   = pkt_cnt_q + ADDR_W'(1);
                        state_d   = ST_LOAD;
                    end
                end
            end
            ST_DONE: begin
                pkt_cnt_d = '0;
                rb1_a_d   = '0;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are flopped from next-state so each bit appears with its SHIFT cycle.
    always_comb begin
        sen_d  = (state_d == ST_SHIFT);
        sd_d   = sen_d & shreg_d[PKT_W-1];
        done_d = (state_d == ST_DONE);
    end

    assign RB1_RW  = 1'b1;
    assign RB1_A   = rb1_a_q;
    assign sen     = sen_q;
    assign sd      = sd_q;
    assign S1_done = done_q;

endmodule

// File: tb/tb_s1_serial_tx.sv
// Scoreboard bench for s1_serial_tx: stimulus pushes expected bits and S1_done
// cycles; a monitor pops them and rebuilds packets into an RB2 model.
module tb_s1_serial_tx;
    import s1_serial_tx_pkg::*;

    localparam int unsigned BURST = 1 + NUM_PKT * (PKT_W + 1);

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic              RB1_RW;
    logic [ADDR_W-1:0] RB1_A;
    logic [DATA_W-1:0] RB1_Q;
    logic              sen;
    logic              sd;
    logic              S1_done;

    logic [DATA_W-1:0] mem [NUM_PKT];
    logic [DATA_W-1:0] rb2 [NUM_PKT];

    int unsigned cyc = 0;
    int unsigned chk_cnt = 0;
    int unsigned pass_cnt = 0;

    bit          exp_bits [$];
    int unsigned done_q   [$];
    bit          aborted = 1'b0;

    logic [PKT_W-1:0] rx_sh = '0;
    int unsigned      run_len = 0;
    int unsigned      gap_len = 0;
    int unsigned      pkt_seen = 0;
    logic             prev_sen = 1'b0;

    s1_serial_tx dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .RB1_RW  (RB1_RW),
        .RB1_A   (RB1_A),
        .RB1_Q   (RB1_Q),
        .sen     (sen),
        .sd      (sd),
        .S1_done (S1_done)
    );

    assign RB1_Q = mem[RB1_A];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: sampled 1 time unit after the active edge.
    always @(posedge clk) begin
        #1;
        if (sen) begin
            if (!prev_sen) begin
                if (pkt_seen != 0) check("gap_len", gap_len, 1);
                run_len = 0;
            end
            if (exp_bits.size() == 0) check("unexpected_sen", {31'b0, sen}, 0);
            else check("sd_bit", {31'b0, sd}, {31'b0, exp_bits.pop_front()});
            rx_sh = {rx_sh[PKT_W-2:0], sd};
            run_len++;
        end else begin
            check("sd_idle", {31'b0, sd}, 0);
            if (prev_sen) begin
                if (aborted) begin
                    pkt_seen = 0;
                end else begin
                    check("run_len", run_len, PKT_W);
                    rb2[rx_sh[PKT_W-1 -: ADDR_W]] = rx_sh[DATA_W-1:0];
                    pkt_seen = (pkt_seen + 1) % NUM_PKT;
                end
                gap_len = 0;
            end
            gap_len++;
        end
        if (S1_done) begin
            if (done_q.size() == 0) check("unexpected_done", {31'b0, S1_done}, 0);
            else check("done_cycle", cyc, done_q.pop_front());
        end
        prev_sen = sen;
    end

    task automatic push_burst(input int unsigned n0);
        for (int unsigned p = 0; p < NUM_PKT; p++) begin
            logic [PKT_W-1:0] pk;
            pk = {ADDR_W'(p), mem[p]};
            for (int b = PKT_W - 1; b >= 0; b--) exp_bits.push_back(pk[b]);
        end
        done_q.push_back(n0 + BURST);
    endtask

    task automatic pulse_start(input bit expect_burst, output int unsigned n0);
        @(negedge clk);
        start = 1'b1;
        n0 = cyc;
        if (expect_burst) push_burst(n0);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_at(input int unsigned when);
        while (cyc < when) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int unsigned budget);
        int unsigned k = 0;
        while ((done_q.size() != 0 || exp_bits.size() != 0) && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(name, done_q.size() + exp_bits.size(), 0);
    endtask

    task automatic clear_rb2();
        for (int unsigned i = 0; i < NUM_PKT; i++) rb2[i] = 'x;
    endtask

    task automatic check_rb2();
        for (int unsigned i = 0; i < NUM_PKT; i++) check("rb2_word", 32'(rb2[i]), 32'(mem[i]));
    endtask

    initial begin
        int unsigned n0;
        for (int unsigned i = 0; i < NUM_PKT; i++) mem[i] = 18'h2AAAA ^ DATA_W'(i);
        clear_rb2();

        // Reset held for 3 cycles
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_sen", {31'b0, sen}, 0);
        check("rst_sd", {31'b0, sd}, 0);
        check("rst_done", {31'b0, S1_done}, 0);
        check("rst_addr", 32'(RB1_A), 0);
        check("rst_rw", {31'b0, RB1_RW}, 1);
        rst = 1'b1;
        @(negedge clk);

        // Start asserted together with reset: reset wins
        rst = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rst = 1'b1;
        repeat (5) @(negedge clk);
        check("start_in_reset", {31'b0, sen}, 0);

        // Full burst, loopback into the RB2 model
        clear_rb2();
        pulse_start(1'b1, n0);
        wait_idle("burst1_timeout", 400);
        check_rb2();
        check("pkt0_word", 32'(rb2[0]), 32'h2AAAA);
        check("pkt7_word", 32'(rb2[7]), 32'h2AAAD);

        // All-ones then all-zeros data in adjacent packets
        mem[3] = 18'h3FFFF;
        mem[4] = 18'h00000;
        clear_rb2();
        pulse_start(1'b1, n0);
        wait_idle("burst2_timeout", 400);
        check("pkt3_ones", 32'(rb2[3]), 32'h3FFFF);
        check("pkt4_zeros", 32'(rb2[4]), 32'h00000);
        check("pkt5_word", 32'(rb2[5]), 32'h2AAAF);

        // Start re-pulsed while busy and during S1_done: ignored
        pulse_start(1'b1, n0);
        pulse_at(n0 + 40);
        pulse_at(n0 + 176);
        pulse_at(n0 + 177);
        wait_idle("burst3_timeout", 400);
        repeat (40) @(negedge clk);
        check("no_rerun_sen", {31'b0, sen}, 0);
        check("no_rerun_done", {31'b0, S1_done}, 0);

        // Reset during bit 10 of packet 5 aborts; fresh start restarts at address 0
        pulse_start(1'b1, n0);
        while (cyc < n0 + 122) @(negedge clk);
        check("abort_mid_sen", {31'b0, sen}, 1);
        aborted = 1'b1;
        rst = 1'b0;
        exp_bits.delete();
        done_q.delete();
        @(negedge clk);
        check("abort_sen", {31'b0, sen}, 0);
        check("abort_done", {31'b0, S1_done}, 0);
        check("abort_addr", 32'(RB1_A), 0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        aborted = 1'b0;
        check("abort_idle_sen", {31'b0, sen}, 0);
        clear_rb2();
        pulse_start(1'b1, n0);
        wait_idle("burst4_timeout", 400);
        check_rb2();

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule
